// File: rtl/id_issue_hazard_scheduler_if.sv
// Issue-side bundle between the decoder and the hazard scheduler.
// The decoder drives the instruction fields; the scheduler answers with stall info.
interface id_issue_hazard_scheduler_if #(
  parameter int RF_ADDR_W = 5,
  parameter int CNT_W     = 16,
  parameter int PIPE_W    = 2
);
  logic                 issue_valid_i;
  logic [PIPE_W-1:0]    pipe_type_i;
  logic                 wr_en_i;
  logic [RF_ADDR_W-1:0] wr_sel_i;
  logic                 rd_a_en_i;
  logic [RF_ADDR_W-1:0] rd_a_sel_i;
  logic                 rd_b_en_i;
  logic [RF_ADDR_W-1:0] rd_b_sel_i;
  logic                 mac_use_i;
  logic                 stall_o;
  logic [2:0]           stall_cause_o;
  logic [CNT_W-1:0]     stall_cnt_o;

  modport master (
    output issue_valid_i, pipe_type_i, wr_en_i, wr_sel_i,
           rd_a_en_i, rd_a_sel_i, rd_b_en_i, rd_b_sel_i, mac_use_i,
    input  stall_o, stall_cause_o, stall_cnt_o
  );

  modport slave (
    input  issue_valid_i, pipe_type_i, wr_en_i, wr_sel_i,
           rd_a_en_i, rd_a_sel_i, rd_b_en_i, rd_b_sel_i, mac_use_i,
    output stall_o, stall_cause_o, stall_cnt_o
  );
endinterface

// File: rtl/id_issue_hazard_scheduler.sv
// Issue-stage interlock: reserves future RF write cycles and CONV MAC cycles,
// and stalls issue on write-port, RAW and MAC conflicts.
module id_issue_hazard_scheduler #(
  parameter int                RF_ADDR_W = 5,
  parameter int                CNT_W     = 16,
  parameter int                FWD_EN    = 1,
  parameter int                PIPE_W    = 2,
  parameter logic [PIPE_W-1:0] E2_PIPE   = PIPE_W'(1),
  parameter logic [PIPE_W-1:0] CONV_PIPE = PIPE_W'(2)
) (
  input logic                        clk_i,
  input logic                        reset_i,
  id_issue_hazard_scheduler_if.slave bus
);

  typedef struct packed {
    logic                 v;
    logic [RF_ADDR_W-1:0] sel;
    logic                 e2;
  } wslot_t;

  // wslot_q[k]: RF write landing k cycles from now; slot 0 is the write landing
  // this cycle, which the RF read in ID cannot see yet, so it still blocks.
  wslot_t [3:0]     wslot_q, wslot_d;
  // mbusy_q[k]: MAC taken by a CONV op k cycles from now.
  logic   [2:1]     mbusy_q, mbusy_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic is_e2, is_conv;
  logic cause_wb, cause_raw, cause_mac;
  logic stall, accept;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    is_e2     = (bus.pipe_type_i == E2_PIPE);
    is_conv   = (bus.pipe_type_i == CONV_PIPE);
    cause_raw = 1'b0;

    for (int k = 0; k < 4; k++) begin
      if (wslot_q[k].v && (wslot_q[k].e2 || (FWD_EN == 0))) begin
        cause_raw = cause_raw
                  | (bus.rd_a_en_i && (wslot_q[k].sel == bus.rd_a_sel_i))
                  | (bus.rd_b_en_i && (wslot_q[k].sel == bus.rd_b_sel_i));
      end
    end

    cause_raw = cause_raw & bus.issue_valid_i & !reset_i;
    cause_wb  = bus.issue_valid_i & bus.wr_en_i & !is_e2 & wslot_q[3].v & !reset_i;
    cause_mac = bus.issue_valid_i & bus.mac_use_i & !is_conv & mbusy_q[1] & !reset_i;

    stall  = reset_i | cause_wb | cause_raw | cause_mac;
    accept = bus.issue_valid_i & !stall;

    wslot_d[2:0] = wslot_q[3:1];
    wslot_d[3]   = '0;
    if (accept && bus.wr_en_i) begin
      if (is_e2) wslot_d[3] = '{v: 1'b1, sel: bus.wr_sel_i, e2: 1'b1};
      else       wslot_d[2] = '{v: 1'b1, sel: bus.wr_sel_i, e2: 1'b0};
    end

    mbusy_d[1] = mbusy_q[2];
    mbusy_d[2] = accept & bus.mac_use_i & is_conv;

    stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      // NOTE: the reservation tables are reset, not left to settle: a stale
      // entry after reset would stall fresh issues on phantom hazards.
      wslot_q     <= '0;
      mbusy_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      wslot_q     <= wslot_d;
      mbusy_q     <= mbusy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_o       = stall;
  assign bus.stall_cause_o = {cause_mac, cause_raw, cause_wb};
  assign bus.stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_id_issue_hazard_scheduler.sv
// Directed bench: one forwarding scheduler and one non-forwarding scheduler
// driven with the same issue stream, checked against hand-derived stall tables.
module tb_id_issue_hazard_scheduler;

  localparam logic [1:0] P_N = 2'd0, P_E2 = 2'd1, P_CONV = 2'd2;

  typedef struct {
    logic       valid;
    logic [1:0] pipe;
    logic       wr_en;
    logic [4:0] wr_sel;
    logic       ra_en;
    logic [4:0] ra;
    logic       rb_en;
    logic [4:0] rb;
    logic       mac;
    logic [3:0] exp;     // {stall, cause} expected from the forwarding DUT
    logic [3:0] exp_nf;  // {stall, cause} expected from the non-forwarding DUT
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  id_issue_hazard_scheduler_if #(.RF_ADDR_W(5), .CNT_W(16), .PIPE_W(2)) bus ();
  id_issue_hazard_scheduler_if #(.RF_ADDR_W(5), .CNT_W(16), .PIPE_W(2)) bus_nf ();

  id_issue_hazard_scheduler #(.RF_ADDR_W(5), .CNT_W(16), .FWD_EN(1)) dut (
    .clk_i(clk), .reset_i(reset), .bus(bus)
  );
  id_issue_hazard_scheduler #(.RF_ADDR_W(5), .CNT_W(16), .FWD_EN(0)) dut_nf (
    .clk_i(clk), .reset_i(reset), .bus(bus_nf)
  );

  function automatic vec_t mk(bit val, logic [1:0] p, bit w, int ws, bit ae, int a,
                              bit be, int b, bit m, logic [3:0] e, logic [3:0] enf);
    vec_t r;
    r.valid = val; r.pipe = p; r.wr_en = w; r.wr_sel = 5'(ws);
    r.ra_en = ae; r.ra = 5'(a); r.rb_en = be; r.rb = 5'(b); r.mac = m;
    r.exp = e; r.exp_nf = enf;
    return r;
  endfunction

  task automatic drive(input vec_t v);
    bus.issue_valid_i = v.valid;     bus_nf.issue_valid_i = v.valid;
    bus.pipe_type_i   = v.pipe;      bus_nf.pipe_type_i   = v.pipe;
    bus.wr_en_i       = v.wr_en;     bus_nf.wr_en_i       = v.wr_en;
    bus.wr_sel_i      = v.wr_sel;    bus_nf.wr_sel_i      = v.wr_sel;
    bus.rd_a_en_i     = v.ra_en;     bus_nf.rd_a_en_i     = v.ra_en;
    bus.rd_a_sel_i    = v.ra;        bus_nf.rd_a_sel_i    = v.ra;
    bus.rd_b_en_i     = v.rb_en;     bus_nf.rd_b_en_i     = v.rb_en;
    bus.rd_b_sel_i    = v.rb;        bus_nf.rd_b_sel_i    = v.rb;
    bus.mac_use_i     = v.mac;       bus_nf.mac_use_i     = v.mac;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(mk(0, P_N, 0, 0, 0, 0, 0, 0, 0, 4'b0, 4'b0));
    #2;
    if ({bus.stall_o, bus.stall_cause_o} !== 4'b1000) begin
      n_err++; $display("FAIL reset_out: got %b want 1000", {bus.stall_o, bus.stall_cause_o});
    end
    n_vec++;
    if (bus.stall_cnt_o !== 16'd0) begin
      n_err++; $display("FAIL reset_cnt: got %0d want 0", bus.stall_cnt_o);
    end
    n_vec++;
    next();
    reset = 1'b0;
    @(negedge clk);
    if ({bus.stall_o, bus.stall_cause_o, bus.stall_cnt_o} !== {4'b0000, 16'd0}) begin
      n_err++; $display("FAIL reset_release: got %b/%0d want 0000/0",
                        {bus.stall_o, bus.stall_cause_o}, bus.stall_cnt_o);
    end
    n_vec++;
  endtask

  task automatic test_wb_port();
    vec_t t[$];
    t = '{mk(1, P_E2, 1, 3, 0, 0, 0, 0, 0, 4'b0000, 4'b0000),
          mk(1, P_N,  1, 4, 0, 0, 0, 0, 0, 4'b1001, 4'b1001),
          mk(1, P_N,  1, 4, 0, 0, 0, 0, 0, 4'b0000, 4'b0000),
          mk(0, P_N,  0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000),
          mk(0, P_N,  0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000),
          mk(0, P_N,  0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000),
          mk(0, P_N,  0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000)};
    foreach (t[i]) begin
      next(); drive(t[i]); @(negedge clk);
      if ({bus.stall_o, bus.stall_cause_o} !== t[i].exp) begin
        n_err++; $display("FAIL wb_port[%0d]: got %b want %b", i, {bus.stall_o, bus.stall_cause_o}, t[i].exp);
      end
      n_vec++;
      if ({bus_nf.stall_o, bus_nf.stall_cause_o} !== t[i].exp_nf) begin
        n_err++; $display("FAIL wb_port_nf[%0d]: got %b want %b", i, {bus_nf.stall_o, bus_nf.stall_cause_o}, t[i].exp_nf);
      end
      n_vec++;
    end
    if (bus.stall_cnt_o !== 16'd1) begin
      n_err++; $display("FAIL wb_port_cnt: got %0d want 1", bus.stall_cnt_o);
    end
    n_vec++;
  endtask

  task automatic test_forwarding();
    vec_t t[$];
    t = '{mk(1, P_N, 1, 5, 0, 0, 0, 0, 0, 4'b0000, 4'b0000),
          mk(1, P_N, 0, 0, 1, 5, 0, 0, 0, 4'b0000, 4'b1010),
          mk(1, P_N, 0, 0, 1, 5, 0, 0, 0, 4'b0000, 4'b1010),
          mk(1, P_N, 0, 0, 1, 5, 0, 0, 0, 4'b0000, 4'b1010),
          mk(1, P_N, 0, 0, 1, 5, 0, 0, 0, 4'b0000, 4'b0000),
          mk(1, P_N, 1, 9, 0, 0, 0, 0, 0, 4'b0000, 4'b0000),
          mk(1, P_N, 0, 0, 1, 8, 0, 9, 0, 4'b0000, 4'b0000),
          mk(1, P_N, 0, 0, 0, 0, 1, 9, 0, 4'b0000, 4'b1010),
          mk(0, P_N, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000),
          mk(0, P_N, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000),
          mk(0, P_N, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000)};
    foreach (t[i]) begin
      next(); drive(t[i]); @(negedge clk);
      if ({bus.stall_o, bus.stall_cause_o} !== t[i].exp) begin
        n_err++; $display("FAIL fwd[%0d]: got %b want %b", i, {bus.stall_o, bus.stall_cause_o}, t[i].exp);
      end
      n_vec++;
      if ({bus_nf.stall_o, bus_nf.stall_cause_o} !== t[i].exp_nf) begin
        n_err++; $display("FAIL nofwd[%0d]: got %b want %b", i, {bus_nf.stall_o, bus_nf.stall_cause_o}, t[i].exp_nf);
      end
      n_vec++;
    end
    if (bus.stall_cnt_o !== 16'd1) begin
      n_err++; $display("FAIL fwd_cnt: got %0d want 1", bus.stall_cnt_o);
    end
    n_vec++;
    if (bus_nf.stall_cnt_o !== 16'd5) begin
      n_err++; $display("FAIL nofwd_cnt: got %0d want 5", bus_nf.stall_cnt_o);
    end
    n_vec++;
  endtask

  task automatic test_e2_raw();
    vec_t t[$];
    t = '{mk(1, P_E2, 1, 2, 0, 0, 0, 0, 0, 4'b0000, 4'b0000),
          mk(1, P_N,  0, 0, 1, 3, 1, 2, 0, 4'b1010, 4'b1010),
          mk(1, P_N,  0, 0, 1, 3, 1, 2, 0, 4'b1010, 4'b1010),
          mk(1, P_N,  0, 0, 1, 3, 1, 2, 0, 4'b1010, 4'b1010),
          mk(1, P_N,  0, 0, 1, 3, 1, 2, 0, 4'b1010, 4'b1010),
          mk(1, P_N,  0, 0, 1, 3, 1, 2, 0, 4'b0000, 4'b0000),
          mk(1, P_E2, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000),
          mk(1, P_N,  0, 0, 1, 1, 0, 0, 0, 4'b0000, 4'b0000),
          mk(1, P_N,  0, 0, 1, 0, 0, 0, 0, 4'b1010, 4'b1010),
          mk(0, P_N,  0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000),
          mk(0, P_N,  0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000),
          mk(1, P_E2, 1, 6, 0, 0, 0, 0, 0, 4'b0000, 4'b0000),
          mk(1, P_N,  1, 7, 1, 6, 0, 0, 0, 4'b1011, 4'b1011),
          mk(1, P_N,  1, 7, 1, 6, 0, 0, 0, 4'b1010, 4'b1010),
          mk(1, P_N,  1, 7, 1, 6, 0, 0, 0, 4'b1010, 4'b1010),
          mk(1, P_N,  1, 7, 1, 6, 0, 0, 0, 4'b1010, 4'b1010),
          mk(1, P_N,  1, 7, 1, 6, 0, 0, 0, 4'b0000, 4'b0000),
          mk(0, P_N,  0, 0, 1, 7, 0, 0, 0, 4'b0000, 4'b0000),
          mk(0, P_N,  0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000),
          mk(0, P_N,  0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000),
          mk(0, P_N,  0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000)};
    foreach (t[i]) begin
      next(); drive(t[i]); @(negedge clk);
      if ({bus.stall_o, bus.stall_cause_o} !== t[i].exp) begin
        n_err++; $display("FAIL e2_raw[%0d]: got %b want %b", i, {bus.stall_o, bus.stall_cause_o}, t[i].exp);
      end
      n_vec++;
      if ({bus_nf.stall_o, bus_nf.stall_cause_o} !== t[i].exp_nf) begin
        n_err++; $display("FAIL e2_raw_nf[%0d]: got %b want %b", i, {bus_nf.stall_o, bus_nf.stall_cause_o}, t[i].exp_nf);
      end
      n_vec++;
    end
  endtask

  task automatic test_mac();
    vec_t t[$];
    t = '{mk(1, P_CONV, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000),
          mk(1, P_N,    0, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000),
          mk(1, P_N,    0, 0, 0, 0, 0, 0, 1, 4'b1100, 4'b1100),
          mk(1, P_N,    0, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000),
          mk(1, P_CONV, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000),
          mk(0, P_N,    0, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000),
          mk(1, P_CONV, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000),
          mk(0, P_N,    0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000),
          mk(1, P_N,    0, 0, 0, 0, 0, 0, 1, 4'b1100, 4'b1100),
          mk(1, P_N,    0, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000)};
    foreach (t[i]) begin
      next(); drive(t[i]); @(negedge clk);
      if ({bus.stall_o, bus.stall_cause_o} !== t[i].exp) begin
        n_err++; $display("FAIL mac[%0d]: got %b want %b", i, {bus.stall_o, bus.stall_cause_o}, t[i].exp);
      end
      n_vec++;
      if ({bus_nf.stall_o, bus_nf.stall_cause_o} !== t[i].exp_nf) begin
        n_err++; $display("FAIL mac_nf[%0d]: got %b want %b", i, {bus_nf.stall_o, bus_nf.stall_cause_o}, t[i].exp_nf);
      end
      n_vec++;
    end
  endtask

  // A self-dependent E2 op re-presented every cycle stalls 4 of every 5 cycles,
  // so 84000 cycles push well past 65535 stalls.
  task automatic test_saturation();
    next();
    drive(mk(1, P_E2, 1, 1, 1, 1, 0, 0, 0, 4'b0, 4'b0));
    repeat (84000) next();
    @(negedge clk);
    if (bus.stall_cnt_o !== 16'hFFFF) begin
      n_err++; $display("FAIL sat_cnt: got %h want ffff", bus.stall_cnt_o);
    end
    n_vec++;
    repeat (10) next();
    @(negedge clk);
    if (bus.stall_cnt_o !== 16'hFFFF) begin
      n_err++; $display("FAIL sat_hold: got %h want ffff", bus.stall_cnt_o);
    end
    n_vec++;
    if (bus_nf.stall_cnt_o !== 16'hFFFF) begin
      n_err++; $display("FAIL sat_cnt_nf: got %h want ffff", bus_nf.stall_cnt_o);
    end
    n_vec++;
    drive(mk(0, P_N, 0, 0, 0, 0, 0, 0, 0, 4'b0, 4'b0));
    repeat (5) next();
  endtask

  task automatic test_reset_mid();
    vec_t t[$];
    t = '{mk(1, P_E2, 1, 2, 0, 0, 0, 0, 0, 4'b0000, 4'b0000),
          mk(1, P_N,  0, 0, 0, 0, 1, 2, 0, 4'b1010, 4'b1010)};
    foreach (t[i]) begin
      next(); drive(t[i]); @(negedge clk);
      if ({bus.stall_o, bus.stall_cause_o} !== t[i].exp) begin
        n_err++; $display("FAIL rst_mid[%0d]: got %b want %b", i, {bus.stall_o, bus.stall_cause_o}, t[i].exp);
      end
      n_vec++;
    end
    #2;
    reset = 1'b1;
    #1;
    if ({bus.stall_o, bus.stall_cause_o, bus.stall_cnt_o} !== {4'b1000, 16'd0}) begin
      n_err++; $display("FAIL rst_async: got %b/%0d want 1000/0",
                        {bus.stall_o, bus.stall_cause_o}, bus.stall_cnt_o);
    end
    n_vec++;
    next();
    if ({bus_nf.stall_o, bus_nf.stall_cause_o, bus_nf.stall_cnt_o} !== {4'b1000, 16'd0}) begin
      n_err++; $display("FAIL rst_hold_nf: got %b/%0d want 1000/0",
                        {bus_nf.stall_o, bus_nf.stall_cause_o}, bus_nf.stall_cnt_o);
    end
    n_vec++;
    reset = 1'b0;
    @(negedge clk);
    if ({bus.stall_o, bus.stall_cause_o, bus.stall_cnt_o} !== {4'b0000, 16'd0}) begin
      n_err++; $display("FAIL rst_after: got %b/%0d want 0000/0",
                        {bus.stall_o, bus.stall_cause_o}, bus.stall_cnt_o);
    end
    n_vec++;
    if ({bus_nf.stall_o, bus_nf.stall_cause_o} !== 4'b0000) begin
      n_err++; $display("FAIL rst_after_nf: got %b want 0000", {bus_nf.stall_o, bus_nf.stall_cause_o});
    end
    n_vec++;
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_wb_port();
    test_forwarding();
    test_e2_raw();
    test_mac();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
